// File: rtl/gray_decoder_pkg.sv
// Shared defaults and Gray/binary helpers for the Gray decoder
// and the encoder/decoder benches that reuse them.
package gray_decoder_pkg;

    localparam int MSB_DEF   = 7;
    localparam int CNT_W_DEF = 16;

    function automatic logic [MSB_DEF:0] gray_to_bin(
        input logic [MSB_DEF:0] g
    );
        logic [MSB_DEF:0] b;
        b[MSB_DEF] = g[MSB_DEF];
        for (int k = MSB_DEF - 1; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    function automatic logic [MSB_DEF:0] bin_to_gray(
        input logic [MSB_DEF:0] b
    );
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_decoder_gray2bin.sv
// Combinational Gray-to-binary converter.
// Binary bit k is the XOR of all Gray bits from MSB down to k.
module gray2bin
    import gray_decoder_pkg::*;
#(
    parameter int MSB = MSB_DEF
) (
    input  logic [MSB:0] gray_i,
    output logic [MSB:0] bin_o
);

    for (genvar k = 0; k <= MSB; k++) begin : g_bit
        assign bin_o[k] = ^(gray_i >> k);
    end

endmodule

// File: rtl/gray_decoder.sv
// Two-stage Gray decoder with unit-distance step checking,
// direction flag and a saturating step-error counter.
module gray_decoder
    import gray_decoder_pkg::*;
#(
    parameter int MSB   = MSB_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [MSB:0]     i_gray,
    output logic             o_vld,
    output logic [MSB:0]     o_data,
    output logic             o_step_err,
    output logic             o_dir,
    output logic [CNT_W-1:0] o_err_cnt
);

    localparam logic [MSB:0]     ONE_W = {{MSB{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [MSB:0]     s1_gray_q;
    logic             s1_en_q;
    logic [MSB:0]     prev_gray_q;
    logic             has_prev_q;
    logic             s2_vld_q;
    logic [MSB:0]     s2_data_q;
    logic             s2_err_q;
    logic             s2_dir_q;
    logic             vld_q;
    logic [MSB:0]     data_q;
    logic             err_q;
    logic             dir_q;
    logic [CNT_W-1:0] cnt_q;

    logic [MSB:0]     cur_bin;
    logic [MSB:0]     prev_bin;
    logic [MSB:0]     diff;
    logic             err_d;
    logic             dir_d;
    logic [CNT_W-1:0] cnt_d;

    gray2bin #(.MSB(MSB)) u_cur (
        .gray_i (s1_gray_q),
        .bin_o  (cur_bin)
    );

    gray2bin #(.MSB(MSB)) u_prev (
        .gray_i (prev_gray_q),
        .bin_o  (prev_bin)
    );

    // Unit distance means exactly one differing bit: zero or multi-bit is an error.
    always_comb begin
        diff  = s1_gray_q ^ prev_gray_q;
        err_d = has_prev_q &
                ((diff == '0) | (|(diff & (diff - ONE_W))));
        dir_d = has_prev_q & (cur_bin == (prev_bin + ONE_W));
        cnt_d = cnt_q;
        if (s2_vld_q && s2_err_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + ONE_C;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_gray_q <= '0;
            s1_en_q   <= 1'b0;
        end else begin
            s1_gray_q <= i_gray;
            s1_en_q   <= i_en;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s2_vld_q    <= 1'b0;
            s2_data_q   <= '0;
            s2_err_q    <= 1'b0;
            s2_dir_q    <= 1'b0;
            prev_gray_q <= '0;
            has_prev_q  <= 1'b0;
        end else begin
            s2_vld_q <= s1_en_q;
            if (s1_en_q) begin
                s2_data_q   <= cur_bin;
                s2_err_q    <= err_d;
                s2_dir_q    <= dir_d;
                prev_gray_q <= s1_gray_q;
                has_prev_q  <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            err_q  <= 1'b0;
            dir_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            vld_q <= s2_vld_q;
            cnt_q <= cnt_d;
            if (s2_vld_q) begin
                data_q <= s2_data_q;
                err_q  <= s2_err_q;
                dir_q  <= s2_dir_q;
            end
        end
    end

    assign o_vld      = vld_q;
    assign o_data     = data_q;
    assign o_step_err = err_q;
    assign o_dir      = dir_q;
    assign o_err_cnt  = cnt_q;

endmodule

// File: tb/tb_gray_decoder.sv
// Scoreboard bench for gray_decoder: directed vectors push expected
// results, a negedge monitor pops them whenever o_vld is seen.
module tb_gray_decoder;

    localparam int MSB   = 7;
    localparam int CNT_W = 3;

    typedef struct {
        logic [MSB:0] d;
        logic         e;
        logic         r;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [MSB:0]     gray;
    logic             vld;
    logic [MSB:0]     data;
    logic             step_err;
    logic             dir;
    logic [CNT_W-1:0] err_cnt;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   cyc;
    int   last_vld;
    int   prev_vld;

    gray_decoder #(.MSB(MSB), .CNT_W(CNT_W)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_gray     (gray),
        .o_vld      (vld),
        .o_data     (data),
        .o_step_err (step_err),
        .o_dir      (dir),
        .o_err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (vld === 1'b1) begin
            prev_vld = last_vld;
            last_vld = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stray_vld data=%0d expected=no_output", data);
            end else begin
                e = exp_q.pop_front();
                chk("data", int'(data), int'(e.d));
                chk("step_err", int'(step_err), int'(e.e));
                chk("dir", int'(dir), int'(e.r));
            end
        end
    end

    task automatic send(input logic [MSB:0] g, input logic [MSB:0] d,
                        input logic e, input logic r);
        exp_t x;
        @(negedge clk);
        en   = 1'b1;
        gray = g;
        x.d = d;
        x.e = e;
        x.r = r;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        idle(1);
        while (exp_q.size() != 0 && n < 20) begin
            idle(1);
            n++;
        end
        chk({name, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_zero(input string name);
        chk({name, "_vld"}, int'(vld), 0);
        chk({name, "_data"}, int'(data), 0);
        chk({name, "_err"}, int'(step_err), 0);
        chk({name, "_dir"}, int'(dir), 0);
        chk({name, "_cnt"}, int'(err_cnt), 0);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        check_zero(name);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MSB:0] g;
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        last_vld = 0;
        prev_vld = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        gray     = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) begin
            g = 8'(i ^ (i >> 1));
            send(g, 8'(i), 1'b0, i != 0);
        end
        drain("sweep");
        chk("sweep_cnt", int'(err_cnt), 0);

        do_reset("rst_wrap");
        send(8'h80, 8'd255, 1'b0, 1'b0);
        send(8'h00, 8'd0, 1'b0, 1'b1);
        drain("wrap");
        chk("wrap_cnt", int'(err_cnt), 0);

        do_reset("rst_skip");
        send(8'h02, 8'd3, 1'b0, 1'b0);
        send(8'h07, 8'd5, 1'b1, 1'b0);
        send(8'h07, 8'd5, 1'b1, 1'b0);
        drain("skip");
        chk("skip_cnt", int'(err_cnt), 2);
        chk("hold_vld", int'(vld), 0);
        chk("hold_data", int'(data), 5);
        chk("hold_err", int'(step_err), 1);

        do_reset("rst_gap");
        send(8'h0F, 8'd10, 1'b0, 1'b0);
        idle(3);
        send(8'h0E, 8'd11, 1'b0, 1'b1);
        drain("gap");
        chk("gap_spacing", last_vld - prev_vld, 4);
        chk("gap_cnt", int'(err_cnt), 0);

        do_reset("rst_down");
        send(8'h1E, 8'd20, 1'b0, 1'b0);
        send(8'h1A, 8'd19, 1'b0, 1'b0);
        drain("down");
        chk("down_cnt", int'(err_cnt), 0);

        do_reset("rst_sat");
        send(8'h00, 8'd0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            send(8'h00, 8'd0, 1'b1, 1'b0);
        end
        drain("sat");
        chk("sat_cnt", int'(err_cnt), 7);

        do_reset("rst_pre_mid");
        for (int i = 0; i < 50; i++) begin
            g = 8'(i ^ (i >> 1));
            send(g, 8'(i), 1'b0, i != 0);
        end
        do_reset("mid");
        idle(3);
        chk("mid_quiet_vld", int'(vld), 0);
        send(8'h22, 8'd60, 1'b0, 1'b0);
        drain("mid_first");
        chk("mid_cnt", int'(err_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
